pit_multi: RTL

Multi-channel programmable interval timer, the parametrised successor of the single-channel mini PIT. NUM_CH independent down-counters with per-channel reload, optional prescaler, one-shot/periodic mode, sticky pending bits with write-1-to-clear acknowledge, and a maskable combined interrupt. Sits behind the chip's byte/word config bus and drives status pins and an interrupt line.

---
 rtl/pit_pkg.sv | 23 ++
 rtl/pit_channel.sv | 116 +++++++++++
 rtl/pit_multi.sv | 83 ++++++++
 3 files changed

// File: rtl/pit_pkg.sv
// Shared register map, CTRL bit layout and ctrl struct for the multi-channel PIT.
package pit_pkg;

  localparam logic [1:0] REG_CTRL      = 2'd0;
  localparam logic [1:0] REG_RELOAD    = 2'd1;
  localparam logic [1:0] REG_PRESCALE  = 2'd2;
  localparam logic [1:0] REG_ACK_COUNT = 2'd3;

  localparam int unsigned CTRL_ENABLE      = 0;
  localparam int unsigned CTRL_PERIODIC    = 1;
  localparam int unsigned CTRL_PRESCALE_EN = 2;
  localparam int unsigned CTRL_IE          = 3;
  localparam int unsigned CTRL_W           = 4;

  // Field order puts enable at bit 0 so the packed value matches the register layout.
  typedef struct packed {
    logic ie;
    logic prescale_en;
    logic periodic;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/pit_channel.sv
// One timer channel: control/reload/prescale registers, down-counter, prescaler and pending bit.
module pit_channel
  import pit_pkg::*;
#(
  parameter int unsigned COUNT_W    = 16,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [1:0]            wr_reg,
  input  logic [COUNT_W-1:0]    wr_data,
  output logic [CTRL_W-1:0]     ctrl,
  output logic [COUNT_W-1:0]    reload,
  output logic [PRESCALE_W-1:0] prescale,
  output logic [COUNT_W-1:0]    count,
  output logic                  pending,
  output logic                  pulse
);

  ctrl_t                  ctrl_q, ctrl_d;
  logic [COUNT_W-1:0]     reload_q, reload_d;
  logic [PRESCALE_W-1:0]  prescale_q, prescale_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic [PRESCALE_W-1:0]  pcnt_q, pcnt_d;
  logic                   pending_q, pending_d;
  logic                   pulse_q, pulse_d;
  logic                   tick;
  logic                   expire;
  logic                   ack;

  always_comb begin
    ctrl_d     = ctrl_q;
    reload_d   = reload_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    pcnt_d     = pcnt_q;
    tick       = 1'b0;
    expire     = 1'b0;
    ack        = 1'b0;

    if (ctrl_q.enable) begin
      if (ctrl_q.prescale_en) begin
        if (pcnt_q == prescale_q) begin
          tick   = 1'b1;
          pcnt_d = '0;
        end else begin
          pcnt_d = pcnt_q + PRESCALE_W'(1);
        end
      end else begin
        tick = 1'b1;
      end
    end

    if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - COUNT_W'(1);
      end else begin
        expire = 1'b1;
        if (ctrl_q.periodic) count_d = reload_q;
        else                 ctrl_d.enable = 1'b0;
      end
    end

    // Register writes take priority over the counting update above.
    if (wr_en) begin
      case (wr_reg)
        REG_CTRL: begin
          ctrl_d.enable      = wr_data[CTRL_ENABLE];
          ctrl_d.periodic    = wr_data[CTRL_PERIODIC];
          ctrl_d.prescale_en = wr_data[CTRL_PRESCALE_EN];
          ctrl_d.ie          = wr_data[CTRL_IE];
          if (wr_data[CTRL_ENABLE] && !ctrl_q.enable) begin
            count_d = reload_q;
            pcnt_d  = '0;
          end
        end
        REG_RELOAD:   reload_d   = wr_data;
        REG_PRESCALE: prescale_d = wr_data[PRESCALE_W-1:0];
        default:      ack        = wr_data[0];
      endcase
    end

    // A same-cycle expiry wins over the acknowledge.
    pending_d = (pending_q & ~ack) | expire;
    pulse_d   = expire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      reload_q   <= '0;
      prescale_q <= '0;
      count_q    <= '0;
      pcnt_q     <= '0;
      pending_q  <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      reload_q   <= reload_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      pcnt_q     <= pcnt_d;
      pending_q  <= pending_d;
      pulse_q    <= pulse_d;
    end
  end

  assign ctrl     = ctrl_q;
  assign reload   = reload_q;
  assign prescale = prescale_q;
  assign count    = count_q;
  assign pending  = pending_q;
  assign pulse    = pulse_q;

endmodule

// File: rtl/pit_multi.sv
// Multi-channel programmable interval timer: address decode, registered read mux, irq combine.
module pit_multi
  import pit_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned COUNT_W    = 16,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_CH)+1:0]  wr_addr,
  input  logic [COUNT_W-1:0]         wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(NUM_CH)+1:0]  rd_addr,
  output logic [COUNT_W-1:0]         rd_data,
  output logic                       rd_valid,
  output logic [NUM_CH-1:0]          irq_pulse,
  output logic [NUM_CH-1:0]          irq_pending,
  output logic                       irq
);

  localparam int unsigned AW = $clog2(NUM_CH) + 2;

  logic [CTRL_W-1:0]     ch_ctrl     [NUM_CH];
  logic [COUNT_W-1:0]    ch_reload   [NUM_CH];
  logic [PRESCALE_W-1:0] ch_prescale [NUM_CH];
  logic [COUNT_W-1:0]    ch_count    [NUM_CH];
  logic [NUM_CH-1:0]     ie_vec;
  logic [COUNT_W-1:0]    rd_mux;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = wr_en && ((wr_addr >> 2) == AW'(i));

    pit_channel #(
      .COUNT_W    (COUNT_W),
      .PRESCALE_W (PRESCALE_W)
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_sel),
      .wr_reg   (wr_addr[1:0]),
      .wr_data  (wr_data),
      .ctrl     (ch_ctrl[i]),
      .reload   (ch_reload[i]),
      .prescale (ch_prescale[i]),
      .count    (ch_count[i]),
      .pending  (irq_pending[i]),
      .pulse    (irq_pulse[i])
    );

    assign ie_vec[i] = ch_ctrl[i][CTRL_IE];
  end

  // Addresses of channels beyond NUM_CH match nothing and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((rd_addr >> 2) == AW'(i)) begin
        case (rd_addr[1:0])
          REG_CTRL:     rd_mux = COUNT_W'(ch_ctrl[i]);
          REG_RELOAD:   rd_mux = ch_reload[i];
          REG_PRESCALE: rd_mux = COUNT_W'(ch_prescale[i]);
          default:      rd_mux = ch_count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

  assign irq = |(irq_pending & ie_vec);

endmodule
